// File: rtl/dest_index_sequencer.sv
// Tags incoming payload words with a cycling destination index and buffers
// {index, data} pairs in a small FIFO for a downstream one-hot decoder.
module dest_index_sequencer #(
  parameter int indexLen  = 3,
  parameter int dataLen   = 16,
  parameter int fifoDepth = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [indexLen:0]   numDest,
  input  logic [15:0]         totalWords,
  input  logic [dataLen-1:0]  in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [indexLen-1:0] out_index,
  output logic [dataLen-1:0]  out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  localparam int AW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int NW = indexLen + 1;
  localparam int EW = indexLen + dataLen;
  localparam logic [AW:0] FullCount = (AW+1)'(fifoDepth);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [indexLen:0]   num_dest_q, num_dest_d;
  logic [15:0]         total_q, total_d;
  logic [indexLen-1:0] idx_q, idx_d;
  logic [15:0]         wcnt_q, wcnt_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;

  logic [EW-1:0] mem [fifoDepth];

  logic push, pop, fifo_full, idx_wrap, last_word;

  assign fifo_full = (count_q == FullCount);
  assign in_ready  = (state_q == RUN) && !fifo_full;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Head is read combinationally; gated so an empty FIFO (incl. reset) presents zeros.
  assign {out_index, out_data} = out_valid ? mem[rd_ptr_q] : '0;

  // numDest==0 means the full index range, which wraps on its own.
  assign idx_wrap  = (num_dest_q != '0) && ({1'b0, idx_q} == (num_dest_q - NW'(1)));
  assign last_word = (wcnt_q == (total_q - 16'd1));

  always_comb begin
    state_d    = state_q;
    num_dest_d = num_dest_q;
    total_d    = total_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_dest_d = numDest;
          total_d    = totalWords;
          idx_d      = '0;
          wcnt_d     = '0;
          state_d    = (totalWords == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (push) begin
          idx_d  = idx_wrap ? '0 : idx_q + indexLen'(1);
          wcnt_d = wcnt_q + 16'd1;
          if (last_word) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == '0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      num_dest_q <= '0;
      total_q    <= '0;
      idx_q      <= '0;
      wcnt_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      num_dest_q <= num_dest_d;
      total_q    <= total_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {idx_q, in_data};
  end

endmodule

// File: tb/tb_dest_index_sequencer.sv
// Randomized bench for dest_index_sequencer against a transaction-level model
// (expected-word queue, modulo index arithmetic, done/busy timing).
module tb_dest_index_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [3:0]  numDest;
  logic [15:0] totalWords, in_data, out_data;
  logic [2:0]  out_index;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit          active = 0;
  int          total = 0, n_eff = 8, accepted = 0, popped = 0, done_cd = -1;
  logic [18:0] q[$];

  dest_index_sequencer #(.indexLen(3), .dataLen(16), .fifoDepth(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .numDest(numDest),
    .totalWords(totalWords), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_index(out_index), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    active = 0; accepted = 0; popped = 0; total = 0; done_cd = -1;
    q.delete();
  endfunction

  // One clock cycle: compare at the falling edge, then advance the model
  // by whatever handshakes happen at the next rising edge.
  task automatic step();
    bit in_rdy_e, ov_e, done_e, was_active;
    logic [18:0] head;
    @(negedge clk);
    in_rdy_e = active && (accepted < total) && (q.size() < DEPTH);
    ov_e     = (q.size() > 0);
    done_e   = (done_cd == 0);
    chk("busy", 32'(busy), 32'(active));
    chk("in_ready", 32'(in_ready), 32'(in_rdy_e));
    chk("out_valid", 32'(out_valid), 32'(ov_e));
    chk("done", 32'(done), 32'(done_e));
    if (ov_e) begin
      head = q[0];
      chk("out_index", 32'(out_index), 32'(head[18:16]));
      chk("out_data", 32'(out_data), 32'(head[15:0]));
    end
    was_active = active;
    if (done_cd == 0) begin
      active = 0; done_cd = -1;
    end else if (done_cd > 0) begin
      done_cd--;
    end
    if (start && !was_active) begin
      active = 1; total = int'(totalWords); accepted = 0; popped = 0;
      n_eff = (numDest == 4'd0) ? 8 : int'(numDest);
      if (total == 0) done_cd = 0;
    end
    if (out_ready && ov_e) begin
      void'(q.pop_front());
      popped++;
      if (popped == total) done_cd = 1;
    end
    if (in_valid && in_rdy_e) begin
      q.push_back({3'(accepted % n_eff), in_data});
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_transfer(input int nd, input int tw, input int pv, input int pr,
                              input int hold, input int inject_at);
    int cyc = 0;
    int budget = tw * 30 + 50;
    start = 1; numDest = 4'(nd); totalWords = 16'(tw);
    in_valid = 0; out_ready = 0;
    step();
    start = 0;
    while (active && cyc < budget) begin
      in_valid  = ($urandom_range(99) < pv);
      in_data   = 16'($urandom);
      out_ready = (cyc >= hold) && ($urandom_range(99) < pr);
      start     = (cyc == inject_at);
      numDest   = 4'(nd + 1);
      totalWords = 16'(tw + 3);
      step();
      cyc++;
    end
    start = 0; in_valid = 0; out_ready = 0;
    chk("transfer_timeout", 32'(active), 32'(0));
    $display("transfer numDest=%0d totalWords=%0d cycles=%0d popped=%0d", nd, tw, cyc, popped);
    step();
  endtask

  initial begin
    reset = 1; start = 0; numDest = 0; totalWords = 0;
    in_data = 0; in_valid = 0; out_ready = 0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out_index", 32'(out_index), 0);
    chk("rst_out_data", 32'(out_data), 0);
    @(posedge clk); #1;
    reset = 0;
    step();

    run_transfer(3, 7, 100, 100, 0, -1);   // index 0,1,2,0,1,2,0
    run_transfer(0, 10, 100, 100, 0, -1);  // full-range wrap 0..7,0,1
    run_transfer(2, 6, 100, 100, 10, -1);  // FIFO fills, then drains in order
    run_transfer(0, 0, 100, 100, 0, -1);   // empty transfer: DONE only
    run_transfer(1, 9, 70, 60, 0, -1);     // every word tagged 0
    run_transfer(5, 12, 100, 100, 0, 3);   // start during RUN is ignored

    // Reset during RUN with two words buffered
    start = 1; numDest = 4'd3; totalWords = 16'd10;
    step();
    start = 0; in_valid = 1; in_data = 16'hA5A5; out_ready = 0;
    step();
    in_data = 16'h5A5A;
    step();
    in_valid = 0;
    reset = 1;
    #2;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_out_index", 32'(out_index), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    model_reset();
    step();
    reset = 0;
    step();
    run_transfer(3, 4, 100, 100, 0, -1);

    for (int t = 0; t < 6; t++) begin
      run_transfer($urandom_range(8, 0), $urandom_range(20, 0),
                   $urandom_range(100, 30), $urandom_range(100, 30),
                   $urandom_range(6, 0), $urandom_range(15, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
